blob_bbox_extractor: RTL and testbench

Per-frame bounding-box extractor for the filtered foreground stream leaving the morphological/segmentation stage. Consumes the 1-bit foreground pixel together with the video raster position. Accumulates min/max coordinates and the pixel count of all foreground pixels in the frame, then publishes the result at end of frame. Draws the previous frame's box as a rectangle overlay on the outgoing 24-bit video.

---
 rtl/blob_bbox_extractor.sv | 134 +++++++++++++
 tb/tb_blob_bbox_extractor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_bbox_extractor.sv
// Per-frame foreground bounding-box extractor with rectangle overlay.
// Publishes min/max/count at end of frame and draws the previous box on video.
module blob_bbox_extractor #(
  parameter int          H_IMG_RES  = 640,
  parameter int          V_IMG_RES  = 480,
  parameter int          MIN_PIXELS = 64,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
  input  logic        app_clk,
  input  logic        app_rst,
  input  logic [10:0] vid_hpos,
  input  logic [10:0] vid_vpos,
  input  logic        vid_active_pix,
  input  logic        fg_px,
  input  logic [23:0] vid_data_in,
  output logic [23:0] vid_data_out,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax,
  output logic [18:0] box_count,
  output logic        box_valid,
  output logic        frame_done
);

  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] ACCUM    = 2'd1;
  localparam logic [1:0] PUBLISH  = 2'd2;

  localparam logic [10:0] H_RES  = 11'(H_IMG_RES);
  localparam logic [10:0] V_RES  = 11'(V_IMG_RES);
  localparam logic [10:0] H_LAST = 11'(H_IMG_RES - 1);
  localparam logic [10:0] V_LAST = 11'(V_IMG_RES - 1);
  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

  logic [1:0]  state;
  logic [10:0] xmin, xmax, ymin, ymax;
  logic [18:0] count;

  logic        in_img, hit, sof, eof;
  logic [10:0] bx0, bx1, by0, by1;
  logic [10:0] nx0, nx1, ny0, ny1;
  logic [18:0] bc, nc;
  logic        on_col, on_row, on_box;

  assign in_img = (vid_hpos < H_RES) && (vid_vpos < V_RES);
  assign hit    = in_img && vid_active_pix && fg_px;
  assign sof    = (vid_hpos == 11'd0) && (vid_vpos == 11'd0);
  assign eof    = (vid_hpos == H_LAST) && (vid_vpos == V_LAST);

  // SOF re-seeds the accumulators and merges its own pixel in the same cycle
  always_comb begin
    bx0 = sof ? H_LAST : xmin;
    bx1 = sof ? 11'd0  : xmax;
    by0 = sof ? V_LAST : ymin;
    by1 = sof ? 11'd0  : ymax;
    bc  = sof ? 19'd0  : count;
    nx0 = (hit && vid_hpos < bx0) ? vid_hpos : bx0;
    nx1 = (hit && vid_hpos > bx1) ? vid_hpos : bx1;
    ny0 = (hit && vid_vpos < by0) ? vid_vpos : by0;
    ny1 = (hit && vid_vpos > by1) ? vid_vpos : by1;
    nc  = bc + 19'(hit);
  end

  always_comb begin
    on_col = (vid_hpos == box_xmin || vid_hpos == box_xmax) &&
             (vid_vpos >= box_ymin) && (vid_vpos <= box_ymax);
    on_row = (vid_vpos == box_ymin || vid_vpos == box_ymax) &&
             (vid_hpos >= box_xmin) && (vid_hpos <= box_xmax);
    on_box = box_valid && in_img && (on_col || on_row);
  end

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state        <= WAIT_SOF;
      xmin         <= '0;
      xmax         <= '0;
      ymin         <= '0;
      ymax         <= '0;
      count        <= '0;
      vid_data_out <= '0;
      box_xmin     <= '0;
      box_xmax     <= '0;
      box_ymin     <= '0;
      box_ymax     <= '0;
      box_count    <= '0;
      box_valid    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      vid_data_out <= on_box ? BOX_COLOR : vid_data_in;
      case (state)
        WAIT_SOF: begin
          if (sof) begin
            xmin  <= nx0;
            xmax  <= nx1;
            ymin  <= ny0;
            ymax  <= ny1;
            count <= nc;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          xmin  <= nx0;
          xmax  <= nx1;
          ymin  <= ny0;
          ymax  <= ny1;
          count <= nc;
          if (eof) state <= PUBLISH;
        end
        PUBLISH: begin
          box_count  <= count;
          frame_done <= 1'b1;
          state      <= WAIT_SOF;
          if (count >= MIN_CNT) begin
            box_xmin  <= xmin;
            box_xmax  <= xmax;
            box_ymin  <= ymin;
            box_ymax  <= ymax;
            box_valid <= 1'b1;
          end else begin
            box_xmin  <= '0;
            box_xmax  <= '0;
            box_ymin  <= '0;
            box_ymax  <= '0;
            box_valid <= 1'b0;
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_bbox_extractor.sv
// Directed bench for blob_bbox_extractor: sparse rasters with SOF/EOF pixels,
// a vector table of foreground rectangles, plus overlay/reset corner cases.
module tb_blob_bbox_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hpos = 11'd800;
  logic [10:0] vpos = 11'd600;
  logic        act = 1'b0;
  logic        fg = 1'b0;
  logic [23:0] din = 24'h0;

  logic [23:0] dout, dout1;
  logic [10:0] x0, x1, y0, y1;
  logic [10:0] a0, a1, b0, b1;
  logic [18:0] cnt, cnt1;
  logic        valid, valid1, done, done1;

  blob_bbox_extractor u_dut (
    .app_clk(clk), .app_rst(rst),
    .vid_hpos(hpos), .vid_vpos(vpos),
    .vid_active_pix(act), .fg_px(fg),
    .vid_data_in(din), .vid_data_out(dout),
    .box_xmin(x0), .box_xmax(x1),
    .box_ymin(y0), .box_ymax(y1),
    .box_count(cnt), .box_valid(valid),
    .frame_done(done)
  );

  blob_bbox_extractor #(.MIN_PIXELS(1)) u_dut1 (
    .app_clk(clk), .app_rst(rst),
    .vid_hpos(hpos), .vid_vpos(vpos),
    .vid_active_pix(act), .fg_px(fg),
    .vid_data_in(din), .vid_data_out(dout1),
    .box_xmin(a0), .box_xmax(a1),
    .box_ymin(b0), .box_ymax(b1),
    .box_count(cnt1), .box_valid(valid1),
    .frame_done(done1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always @(posedge clk) if (done) pulses++;

  typedef struct {
    string name;
    int    x0, x1, y0, y1;
    bit    act, drop;
    int    ex0, ex1, ey0, ey1, ecnt;
    bit    evalid;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(input string n,
    input int rx0, rx1, ry0, ry1, input bit ra, rd,
    input int e0, e1, e2, e3, ec, input bit ev);
    vec_t r;
    r.name = n;
    r.x0 = rx0; r.x1 = rx1; r.y0 = ry0; r.y1 = ry1;
    r.act = ra; r.drop = rd;
    r.ex0 = e0; r.ex1 = e1; r.ey0 = e2; r.ey1 = e3;
    r.ecnt = ec; r.evalid = ev;
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic px(input int h, input int v, input bit a,
                    input bit f, input logic [23:0] d);
    @(negedge clk);
    hpos = 11'(h);
    vpos = 11'(v);
    act  = a;
    fg   = f;
    din  = d;
  endtask

  task automatic blank();
    px(800, 600, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic sof(input bit f);
    px(0, 0, 1'b1, f, 24'h111111);
  endtask

  task automatic eof(input bit f);
    px(639, 479, 1'b1, f, 24'h222222);
  endtask

  task automatic rect(input vec_t r);
    for (int y = r.y0; y <= r.y1; y++)
      for (int x = r.x0; x <= r.x1; x++) begin
        if (!(r.drop && x == r.x1 && y == r.y1))
          px(x, y, r.act, 1'b1, 24'(x));
      end
  endtask

  // called right after the EOF pixel has been driven
  task automatic pub(input string n, input int e0, e1, e2, e3,
                     input int ec, input bit ev);
    @(posedge clk); #1;
    chk({n, ".done_early"}, done, 0);
    blank();
    @(posedge clk); #1;
    chk({n, ".done"}, done, 1);
    chk({n, ".xmin"}, x0, e0);
    chk({n, ".xmax"}, x1, e1);
    chk({n, ".ymin"}, y0, e2);
    chk({n, ".ymax"}, y1, e3);
    chk({n, ".count"}, cnt, ec);
    chk({n, ".valid"}, valid, ev);
    blank();
    @(posedge clk); #1;
    chk({n, ".done_low"}, done, 0);
  endtask

  task automatic probe(input string n, input int h, input int v,
                       input logic [23:0] d, input logic [23:0] exp);
    px(h, v, 1'b1, 1'b0, d);
    @(posedge clk); #1;
    chk(n, dout, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    tbl[0] = mk("empty", 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk("sq10", 100, 109, 50, 59, 1, 0,
                100, 109, 50, 59, 100, 1);
    tbl[2] = mk("p63", 200, 207, 300, 307, 1, 1, 0, 0, 0, 0, 63, 0);
    tbl[3] = mk("p64", 200, 207, 300, 307, 1, 0,
                200, 207, 300, 307, 64, 1);
    tbl[4] = mk("inact", 10, 29, 10, 29, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5] = mk("oob_h", 640, 659, 10, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6] = mk("oob_v", 10, 29, 480, 483, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk("wide", 5, 20, 400, 403, 1, 0, 5, 20, 400, 403, 64, 1);

    // reset state
    din = 24'hABCDEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dout", dout, 0);
    chk("rst.done", done, 0);
    chk("rst.count", cnt, 0);
    chk("rst.valid", valid, 0);
    chk("rst.xmax", x1, 0);
    @(negedge clk);
    rst = 1'b0;

    // passthrough with one cycle of latency
    probe("pass0", 5, 5, 24'h5A5A5A, 24'h5A5A5A);
    probe("pass1", 6, 5, 24'hC3C3C3, 24'hC3C3C3);

    for (int i = 0; i < 8; i++) begin
      sof(1'b0);
      rect(tbl[i]);
      eof(1'b0);
      pub(tbl[i].name, tbl[i].ex0, tbl[i].ex1, tbl[i].ey0,
          tbl[i].ey1, tbl[i].ecnt, tbl[i].evalid);
      if (i == 0) chk("empty.pulses", pulses, 1);
    end
    chk("table.pulses", pulses, 8);

    // overlay of the 10x10 box drawn during the following frame
    sof(1'b0);
    rect(tbl[1]);
    eof(1'b0);
    pub("sq10b", 100, 109, 50, 59, 100, 1);
    probe("ov.sof", 0, 0, 24'h010203, 24'h010203);
    probe("ov.left", 100, 55, 24'h123456, 24'hFF0000);
    probe("ov.bottom", 105, 59, 24'h123456, 24'hFF0000);
    probe("ov.corner", 109, 50, 24'h123456, 24'hFF0000);
    probe("ov.inner", 105, 55, 24'h123456, 24'h123456);
    probe("ov.outx", 99, 55, 24'h654321, 24'h654321);
    probe("ov.outy", 100, 60, 24'h654321, 24'h654321);
    eof(1'b0);
    pub("ovempty", 0, 0, 0, 0, 0, 0);
    probe("ov.gone", 100, 55, 24'h777777, 24'h777777);

    // single pixel at EOF, then at SOF
    sof(1'b0);
    eof(1'b1);
    pub("eof1", 0, 0, 0, 0, 1, 0);
    chk("eof1.m1.xmin", a0, 639);
    chk("eof1.m1.xmax", a1, 639);
    chk("eof1.m1.ymin", b0, 479);
    chk("eof1.m1.ymax", b1, 479);
    chk("eof1.m1.count", cnt1, 1);
    chk("eof1.m1.valid", valid1, 1);
    sof(1'b1);
    eof(1'b0);
    pub("sof1", 0, 0, 0, 0, 1, 0);
    chk("sof1.m1.xmax", a1, 0);
    chk("sof1.m1.ymax", b1, 0);
    chk("sof1.m1.xmin", a0, 0);
    chk("sof1.m1.count", cnt1, 1);
    chk("sof1.m1.valid", valid1, 1);

    // early SOF restart discards the partial frame
    sof(1'b0);
    rect(tbl[1]);
    sof(1'b0);
    rect(tbl[3]);
    eof(1'b0);
    pub("restart", 200, 207, 300, 307, 64, 1);

    // reset in the middle of a frame
    p0 = pulses;
    sof(1'b0);
    rect(tbl[1]);
    px(10, 200, 1'b1, 1'b1, 24'h0);
    rst = 1'b1;
    px(11, 200, 1'b1, 1'b1, 24'h0);
    rst = 1'b0;
    px(12, 250, 1'b1, 1'b1, 24'h0);
    eof(1'b1);
    repeat (5) blank();
    @(posedge clk); #1;
    chk("mrst.no_done", pulses, p0);
    chk("mrst.count", cnt, 0);
    chk("mrst.valid", valid, 0);
    sof(1'b0);
    rect(mk("after", 400, 407, 100, 107, 1, 0, 0, 0, 0, 0, 0, 0));
    eof(1'b0);
    pub("after", 400, 407, 100, 107, 64, 1);
    chk("after.pulses", pulses, p0 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
